// File: rtl/idct_pkg.sv
// Shared definitions for the 8-point 1-D inverse DCT: Q1.14 cosine constants,
// FSM state encoding and the accumulator width helper.
package idct_pkg;

    localparam int unsigned FRAC = 14;
    localparam int unsigned WW   = 16;

    // 0.5*cos(j*pi/16) in Q1.14; C4 doubles as the DC weight 1/(2*sqrt(2))
    localparam logic signed [WW-1:0] C1 = 16'sd8035;
    localparam logic signed [WW-1:0] C2 = 16'sd7568;
    localparam logic signed [WW-1:0] C3 = 16'sd6811;
    localparam logic signed [WW-1:0] C4 = 16'sd5793;
    localparam logic signed [WW-1:0] C5 = 16'sd4551;
    localparam logic signed [WW-1:0] C6 = 16'sd3135;
    localparam logic signed [WW-1:0] C7 = 16'sd1598;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Eight n x 16 products plus headroom never overflow this width
    function automatic int unsigned acc_width(input int unsigned n);
        return n + 19;
    endfunction

endpackage

// File: rtl/idct1d_seq_if.sv
// Coefficient write / start / result read bus of idct1d_seq.
//   wr, add, data_in : coefficient memory write port
//   start, busy, done: transform control and status
//   oe, rd_add, data_out: result memory read port (data_out registered)
interface idct1d_seq_if #(
    parameter int unsigned n = 16
);
    logic                wr;
    logic [2:0]          add;
    logic signed [n-1:0] data_in;
    logic                start;
    logic                busy;
    logic                done;
    logic                oe;
    logic [2:0]          rd_add;
    logic signed [n-1:0] data_out;

    modport master (
        output wr, add, data_in, start, oe, rd_add,
        input  busy, done, data_out
    );

    modport slave (
        input  wr, add, data_in, start, oe, rd_add,
        output busy, done, data_out
    );
endinterface

// File: rtl/idct_weight_rom.sv
// Combinational IDCT basis weight W(k,u) in Q1.14.
//   k   : output sample index 0..7
//   u   : coefficient index 0..7
//   w_c : signed 16-bit weight
module idct_weight_rom
    import idct_pkg::*;
(
    input  logic [2:0]           k,
    input  logic [2:0]           u,
    output logic signed [WW-1:0] w_c
);
    logic [4:0] m_raw;
    logic [4:0] m_fold;

    // Angle index ((2k+1)*u) mod 32 folded onto 0..16; 5-bit product wraps mod 32
    always_comb begin
        m_raw  = {1'b0, k, 1'b1} * {2'b00, u};
        m_fold = (m_raw > 5'd16) ? 5'(6'd32 - {1'b0, m_raw}) : m_raw;
        w_c    = '0;
        if (u == 3'd0) begin
            w_c = C4;
        end else begin
            case (m_fold)
                5'd1:    w_c = C1;
                5'd2:    w_c = C2;
                5'd3:    w_c = C3;
                5'd4:    w_c = C4;
                5'd5:    w_c = C5;
                5'd6:    w_c = C6;
                5'd7:    w_c = C7;
                5'd9:    w_c = -C7;
                5'd10:   w_c = -C6;
                5'd11:   w_c = -C5;
                5'd12:   w_c = -C4;
                5'd13:   w_c = -C3;
                5'd14:   w_c = -C2;
                5'd15:   w_c = -C1;
                default: w_c = '0;
            endcase
        end
    end
endmodule

// File: rtl/idct1d_seq.sv
// Sequential 8-point 1-D IDCT: one multiply-accumulate per cycle, 64 cycles.
//   clk, reset : clock, asynchronous active-high reset
//   bus.slave  : coefficient write, start/busy/done, result read
module idct1d_seq
    import idct_pkg::*;
#(
    parameter int unsigned n = 16
) (
    input  logic        clk,
    input  logic        reset,
    idct1d_seq_if.slave bus
);
    localparam int unsigned AW = acc_width(n);
    localparam int unsigned PW = n + WW;

    localparam logic signed [AW-1:0] RND_HALF = AW'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [AW-1:0] SAT_MAX  = AW'((64'sd1 <<< (n - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(64'sd1 <<< (n - 1)));

    state_t state, state_nxt;
    logic   busy_r, busy_nxt;
    logic   done_r, done_nxt;

    logic [2:0]          k, u;
    logic signed [AW-1:0] acc;
    logic signed [n-1:0]  x_mem [8];
    logic signed [n-1:0]  y_mem [8];
    logic signed [n-1:0]  data_out_r;

    logic signed [WW-1:0] w_c;
    logic signed [PW-1:0] prod_c;
    logic signed [AW-1:0] acc_nxt_c;
    logic signed [AW-1:0] rnd_c;
    logic signed [n-1:0]  sat_c;
    logic                 last_term_c;

    idct_weight_rom u_rom (
        .k   (k),
        .u   (u),
        .w_c (w_c)
    );

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.data_out = data_out_r;

    // MAC term, round-half-up and saturate of the completed sum
    always_comb begin
        prod_c    = PW'(x_mem[u]) * PW'(w_c);
        acc_nxt_c = acc + AW'(prod_c);
        rnd_c     = (acc_nxt_c + RND_HALF) >>> FRAC;
        if (rnd_c > SAT_MAX) begin
            sat_c = n'(SAT_MAX);
        end else if (rnd_c < SAT_MIN) begin
            sat_c = n'(SAT_MIN);
        end else begin
            sat_c = n'(rnd_c);
        end
        last_term_c = (k == 3'd7) && (u == 3'd7);
    end

    // FSM state and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
        end
    end

    // Next state; done is raised together with the final write of y[7]
    always_comb begin
        state_nxt = state;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = COMPUTE;
                    busy_nxt  = 1'b1;
                end
            end
            COMPUTE: begin
                if (last_term_c) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Memories, read port and MAC indices
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k          <= '0;
            u          <= '0;
            acc        <= '0;
            data_out_r <= '0;
            for (int i = 0; i < 8; i++) begin
                x_mem[i] <= '0;
                y_mem[i] <= '0;
            end
        end else begin
            // Coefficients are frozen while the transform runs
            if (bus.wr && !busy_r) begin
                x_mem[bus.add] <= bus.data_in;
            end
            if (bus.oe) begin
                data_out_r <= y_mem[bus.rd_add];
            end
            if (state == IDLE && bus.start) begin
                k   <= '0;
                u   <= '0;
                acc <= '0;
            end else if (state == COMPUTE) begin
                if (u == 3'd7) begin
                    y_mem[k] <= sat_c;
                    acc      <= '0;
                    u        <= '0;
                    k        <= k + 3'd1;
                end else begin
                    acc <= acc_nxt_c;
                    u   <= u + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_idct1d_seq.sv
// Self-checking bench for idct1d_seq against a real-valued cosine model.
module tb_idct1d_seq;
    localparam int unsigned N  = 16;
    localparam real         PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    idct1d_seq_if #(.n(N)) bus();

    idct1d_seq #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [2:0]         rk, ru;
    logic signed [15:0] rw;

    idct_weight_rom rom (
        .k   (rk),
        .u   (ru),
        .w_c (rw)
    );

    int total = 0;
    int bad   = 0;
    int xm  [8];
    int ym  [8];
    int got [8];

    function automatic real basis(input int k, input int u);
        if (u == 0) return 1.0 / (2.0 * $sqrt(2.0));
        return 0.5 * $cos(real'((2 * k + 1) * u) * PI / 16.0);
    endfunction

    function automatic int ref_w(input int k, input int u);
        return int'($floor(basis(k, u) * 16384.0 + 0.5));
    endfunction

    function automatic int ref_y(input int k);
        longint s = 0;
        for (int u = 0; u < 8; u++) s += longint'(xm[u]) * longint'(ref_w(k, u));
        s = (s + 64'sd8192) >>> 14;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    function automatic int rnd_coef();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 2000)) - 1000;
    endfunction

    task automatic load_dut();
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            bus.wr      = 1'b1;
            bus.add     = 3'(a);
            bus.data_in = 16'(xm[a]);
        end
        @(negedge clk);
        bus.wr = 1'b0;
    endtask

    task automatic read_y(input int a, output int v);
        @(negedge clk);
        bus.oe     = 1'b1;
        bus.rd_add = 3'(a);
        @(negedge clk);
        bus.oe = 1'b0;
        v = int'(bus.data_out);
    endtask

    task automatic run_and_check(input string name, input bit with_wr, input int wa, input int wd);
        int lat;
        int v;
        @(negedge clk);
        bus.start = 1'b1;
        if (with_wr) begin
            bus.wr      = 1'b1;
            bus.add     = 3'(wa);
            bus.data_in = 16'(wd);
            xm[wa]      = wd;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr    = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start got=%b exp=1", name, bus.busy);
        end
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        total++;
        if (lat != 64) begin
            bad++;
            $display("FAIL %s done_latency got=%0d exp=64", name, lat);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_at_done got=%b exp=0", name, bus.busy);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_width got=%b exp=0", name, bus.done);
        end
        for (int k = 0; k < 8; k++) ym[k] = ref_y(k);
        for (int k = 0; k < 8; k++) begin
            read_y(k, v);
            got[k] = v;
            total++;
            if (v != ym[k]) begin
                bad++;
                $display("FAIL %s y%0d got=%0d exp=%0d", name, k, v, ym[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.wr      = 1'b0;
        bus.add     = '0;
        bus.data_in = '0;
        bus.start   = 1'b0;
        bus.oe      = 1'b0;
        bus.rd_add  = '0;
        repeat (3) @(negedge clk);
        total += 3;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done got=%b exp=0", bus.done); end
        if (bus.data_out !== 16'sd0) begin bad++; $display("FAIL reset data_out got=%0d exp=0", bus.data_out); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin xm[i] = 0; ym[i] = 0; end
    endtask

    task automatic test_weight_rom();
        for (int k = 0; k < 8; k++) begin
            for (int u = 0; u < 8; u++) begin
                rk = 3'(k);
                ru = 3'(u);
                #1;
                total++;
                if (int'(rw) != ref_w(k, u)) begin
                    bad++;
                    $display("FAIL rom k=%0d u=%0d got=%0d exp=%0d", k, u, rw, ref_w(k, u));
                end
            end
        end
    endtask

    task automatic test_dc();
        for (int i = 0; i < 8; i++) xm[i] = 0;
        xm[0] = 1000;
        load_dut();
        run_and_check("dc", 1'b0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (got[k] != 354) begin bad++; $display("FAIL dc_const y%0d got=%0d exp=354", k, got[k]); end
        end
    endtask

    task automatic test_harmonic();
        for (int i = 0; i < 8; i++) xm[i] = 0;
        xm[1] = 1000;
        load_dut();
        run_and_check("harm", 1'b0, 0, 0);
        total += 4;
        if (got[0] != 490)  begin bad++; $display("FAIL harm_y0 got=%0d exp=490", got[0]); end
        if (got[7] != -490) begin bad++; $display("FAIL harm_y7 got=%0d exp=-490", got[7]); end
        if (got[3] != 98)   begin bad++; $display("FAIL harm_y3 got=%0d exp=98", got[3]); end
        if (got[4] != -98)  begin bad++; $display("FAIL harm_y4 got=%0d exp=-98", got[4]); end
    endtask

    task automatic test_round_trip();
        real s;
        for (int u = 0; u < 8; u++) begin
            s = 0.0;
            for (int k = 0; k < 8; k++) s += real'(10 * k) * basis(k, u);
            xm[u] = int'($floor(s + 0.5));
        end
        load_dut();
        run_and_check("ramp", 1'b0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (got[k] < 10 * k - 1 || got[k] > 10 * k + 1) begin
                bad++;
                $display("FAIL ramp_err y%0d got=%0d exp=%0d+-1", k, got[k], 10 * k);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) xm[i] = 32767;
        load_dut();
        run_and_check("sat_pos", 1'b0, 0, 0);
        total++;
        if (got[0] != 32767) begin bad++; $display("FAIL sat_pos_y0 got=%0d exp=32767", got[0]); end
        for (int i = 0; i < 8; i++) xm[i] = -32768;
        load_dut();
        run_and_check("sat_neg", 1'b0, 0, 0);
        total++;
        if (got[0] != -32768) begin bad++; $display("FAIL sat_neg_y0 got=%0d exp=-32768", got[0]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) xm[i] = rnd_coef();
            load_dut();
            run_and_check("random", 1'b0, 0, 0);
        end
    endtask

    task automatic test_protocol();
        int pulses;
        int first;
        int late_busy;
        int nv;
        int v;
        for (int i = 0; i < 8; i++) xm[i] = rnd_coef();
        nv = (xm[2] == 1234) ? 4321 : 1234;
        load_dut();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses    = 0;
        first     = -1;
        late_busy = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            bus.wr    = 1'b0;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first     = c;
                    bus.start = 1'b1;
                end
            end
            if (first >= 0 && c > first && bus.busy === 1'b1) late_busy++;
            if (c == 10) begin
                bus.wr      = 1'b1;
                bus.add     = 3'd2;
                bus.data_in = 16'(nv);
            end
            if (c == 20) bus.start = 1'b1;
        end
        total += 3;
        if (pulses != 1)    begin bad++; $display("FAIL proto_done_pulses got=%0d exp=1", pulses); end
        if (first != 64)    begin bad++; $display("FAIL proto_latency got=%0d exp=64", first); end
        if (late_busy != 0) begin bad++; $display("FAIL proto_restart got=%0d busy cycles exp=0", late_busy); end
        for (int k = 0; k < 8; k++) ym[k] = ref_y(k);
        for (int k = 0; k < 8; k++) begin
            read_y(k, v);
            total++;
            if (v != ym[k]) begin bad++; $display("FAIL proto_wr_busy y%0d got=%0d exp=%0d", k, v, ym[k]); end
        end
        run_and_check("wr_start", 1'b1, 5, (xm[5] == -777) ? 777 : -777);
    endtask

    task automatic test_reset_midrun();
        int v;
        for (int i = 0; i < 8; i++) xm[i] = rnd_coef();
        xm[0] = 20000;
        load_dut();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        bus.oe     = 1'b1;
        bus.rd_add = 3'd0;
        @(negedge clk);
        bus.oe = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total += 3;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_mid done got=%b exp=0", bus.done); end
        if (bus.data_out !== 16'sd0) begin bad++; $display("FAIL rst_mid data_out got=%0d exp=0", bus.data_out); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin xm[i] = 0; ym[i] = 0; end
        for (int k = 0; k < 8; k++) begin
            read_y(k, v);
            total++;
            if (v != 0) begin bad++; $display("FAIL rst_mid_clear y%0d got=%0d exp=0", k, v); end
        end
        for (int i = 0; i < 8; i++) xm[i] = rnd_coef();
        load_dut();
        run_and_check("after_reset", 1'b0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_weight_rom();
        test_dc();
        test_harmonic();
        test_round_trip();
        test_saturation();
        test_random();
        test_protocol();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idct1d_seq.md
Name: idct1d_seq

Overview:
- 8-point 1-D inverse DCT: the decode-side counterpart of the team's forward 8-point DCT datapath.
- Uses the same orthonormal cosine constants (0.5·cos(jπ/16), DC weight 1/(2√2)), quantised to Q1.14.
- Coefficients are loaded through a wr/add memory port and evaluated by a single sequential multiply-accumulate engine under an FSM.
- The 8 reconstructed samples are read back through an oe/address port.
- Sits after the coefficient-domain stage; rows/columns of a 2-D IDCT are built from two instances plus a transpose buffer.

Parameters:
- n, 16, signed width of input coefficients and output samples.
- FRAC, 14, fractional bits of the cosine constants (fixed; tied to the package).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- wr  in  1  write data_in into coefficient memory at add
- add  in  3  coefficient write address (u = 0..7)
- data_in  in  n  signed coefficient X[u]
- start  in  1  begin transform (accepted only in IDLE)
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when all 8 results are written
- oe  in  1  read enable for result memory
- rd_add  in  3  result read address (k = 0..7)
- data_out  out  n  signed sample y[rd_add], registered

Behaviour:
- Reset (async): FSM to IDLE; k, u and acc cleared; coef memory X[0..7] and result memory y[0..7] set to 0. busy=0, done=0, data_out=0. A reset mid-COMPUTE aborts the transform; no partial result survives.
- Write: on edge with wr=1 and busy=0, X[add] <= data_in. wr while busy=1 is ignored, so the coefficients stay stable for the whole transform.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE: start=1 → COMPUTE, with k=0, u=0, acc=0, busy=1. wr and start in the same cycle: the write lands and is used by the transform.
- COMPUTE: one term per cycle, acc_next = acc + X[u]*W(k,u).
  - When u=7: y[k] <= sat_n((acc_next + 2^(FRAC-1)) >>> FRAC); acc <= 0; u <= 0; k <= k+1.
  - After k=7,u=7 (64th cycle) → DONE, busy <= 0.
  - start during COMPUTE is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Latency: start sampled at edge E0; busy=1 E0..E64; done=1 E64..E65; y valid from E64.
- Weight W(k,u):
  - u=0: C4 = 5793.
  - Otherwise: m = ((2k+1)·u) mod 32; if m>16 then m = 32−m. If m<8, W = C[m]; if m>8, W = −C[16−m]. m=8 cannot occur for u≤7.
  - Q14 table: C1=8035, C2=7568, C3=6811, C4=5793, C5=4551, C6=3135, C7=1598.
- Arithmetic:
  - Product is signed n+16 bits. Accumulator is n+19 bits signed and never overflows.
  - Rounding is round-half-up: add 8192, then arithmetic shift right by 14.
  - Saturate to [−2^(n−1), 2^(n−1)−1].
- Read: on edge with oe=1, data_out <= y[rd_add]; with oe=0, data_out holds.
  - Reads are allowed any time. During COMPUTE, an entry returns its previous value until its k-slot is written.
- Re-start after DONE recomputes from the current X memory; y entries are overwritten one by one.

Decomposition:
- Package idct_pkg holds:
  - FRAC=14 and the C1..C7 Q14 constants.
  - The state enum (IDLE, COMPUTE, DONE).
  - The accumulator width function (n+19).
- One sub-module: idct_weight_rom, a combinational (k,u) → signed 16-bit W. It is unit-testable against a real-valued cosine model.
- MAC, FSM and the two 8-entry memories stay in idct1d_seq.

Test Plan:
- DC only: X0=1000, others 0; start → done at E64; every y[k] = 354 (5793000/16384 = 353.58, rounded).
- First harmonic: X1=1000, others 0 → y0=490, y7=−490. Check y3 = round(1000·1598/16384) = 98 and y4=−98.
- Round-trip: feed the forward-DCT outputs of ramp x=[0,10,...,70] → reconstructed y within ±1 LSB of the ramp.
- Saturation (n=16): all X=32767 → y0 clamps to 32767; a matching negative pattern clamps to −32768.
- Protocol: wr during busy does not alter the result. start during COMPUTE/DONE is ignored, so done pulses once. Simultaneous wr+start in IDLE uses the new value.
- Async reset at cycle 30 of COMPUTE → busy=0, done=0, data_out=0 immediately. All y read back as 0, and a fresh start then completes normally.
